// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position, active-video window and sync measurements from external HSYNC/VSYNC.
// Declares lock once LOCK_FRAMES consecutive frames report identical line and frame totals.
module vga_sync_decoder #(
  parameter int CNT_W        = 11,
  parameter int H_ACTIVE_OFS = 144,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE_OFS = 35,
  parameter int V_ACTIVE     = 480,
  parameter int LOCK_FRAMES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] hsync_width,
  output logic [CNT_W-1:0] vsync_width
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] H_OFS    = CNT_W'(H_ACTIVE_OFS);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_OFS    = CNT_W'(V_ACTIVE_OFS);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

  state_t           state_q, state_d;
  // [0] first sync stage, [1] synchronized sample, [2] previous synchronized sample
  logic [2:0]       hs_q, hs_d, vs_q, vs_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [CNT_W-1:0] hsync_width_q, hsync_width_d, vsync_width_q, vsync_width_d;
  logic [CNT_W-1:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic [3:0]       match_q, match_d;
  logic             vpend_q, vpend_d, h_bad_q, h_bad_d;
  logic             active_q, active_d, frame_start_q, frame_start_d;

  logic             h_fall, h_rise, v_fall, v_rise, fs_evt, h_mis;
  logic [CNT_W-1:0] x_plus1, y_plus1, x_rel, y_rel;

  assign h_fall  = hs_q[2] & ~hs_q[1];
  assign h_rise  = ~hs_q[2] & hs_q[1];
  assign v_fall  = vs_q[2] & ~vs_q[1];
  assign v_rise  = ~vs_q[2] & vs_q[1];
  assign fs_evt  = h_fall & (vpend_q | v_fall);
  assign x_plus1 = x_q + 1'b1;
  assign y_plus1 = y_q + 1'b1;
  assign h_mis   = h_fall && (x_plus1 != h_total_q);

  always_comb begin
    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    x_d           = x_q;
    y_d           = y_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    hsync_width_d = hsync_width_q;
    vsync_width_d = vsync_width_q;
    ref_h_d       = ref_h_q;
    ref_v_d       = ref_v_q;
    match_d       = match_q;
    vpend_d       = vpend_q;
    h_bad_d       = h_bad_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    x_rel         = '0;
    y_rel         = '0;
    if (pix_ce) begin
      hs_d = {hs_q[1:0], hsync_in};
      vs_d = {vs_q[1:0], vsync_in};
      x_d  = (x_q == ALL_ONES) ? x_q : x_plus1;
      if (h_fall) begin
        x_d       = '0;
        h_total_d = x_plus1;
        vpend_d   = 1'b0;
        if (fs_evt) begin
          y_d           = '0;
          v_total_d     = y_plus1;
          frame_start_d = 1'b1;
        end else if (y_q != ALL_ONES) begin
          y_d = y_plus1;
        end
      end else if (v_fall) begin
        vpend_d = 1'b1;
      end
      if (h_rise) hsync_width_d = x_plus1;
      if (v_rise) vsync_width_d = y_d;

      case (state_q)
        SEARCH: begin
          if (fs_evt) begin
            state_d = MEASURE;
            match_d = '0;
            h_bad_d = 1'b0;
          end
        end
        MEASURE: begin
          if (h_mis) h_bad_d = 1'b1;
          if (fs_evt) begin
            h_bad_d = 1'b0;
            ref_h_d = x_plus1;
            ref_v_d = y_plus1;
            // The first clean frame after a restart only seeds the reference.
            if (h_bad_q || h_mis) match_d = '0;
            else if (match_q == 4'd0) match_d = 4'd1;
            else if (x_plus1 == ref_h_q && y_plus1 == ref_v_q) match_d = match_q + 4'd1;
            else match_d = '0;
            if (match_d == LOCK_N) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (h_mis || (fs_evt && y_plus1 != v_total_q)) begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (x_d == ALL_ONES) begin
        state_d = SEARCH;
        match_d = '0;
      end
      // Unsigned offsets wrap in the porches, so one compare per axis suffices.
      x_rel    = x_d - H_OFS;
      y_rel    = y_d - V_OFS;
      active_d = (state_d == LOCKED) && (x_rel < H_ACT) && (y_rel < V_ACT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      hs_q          <= 3'b111;
      vs_q          <= 3'b111;
      x_q           <= '0;
      y_q           <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      hsync_width_q <= '0;
      vsync_width_q <= '0;
      ref_h_q       <= '0;
      ref_v_q       <= '0;
      match_q       <= '0;
      vpend_q       <= 1'b0;
      h_bad_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      hsync_width_q <= hsync_width_d;
      vsync_width_q <= vsync_width_d;
      ref_h_q       <= ref_h_d;
      ref_v_q       <= ref_v_d;
      match_q       <= match_d;
      vpend_q       <= vpend_d;
      h_bad_q       <= h_bad_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign hsync_width = hsync_width_q;
  assign vsync_width = vsync_width_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a randomized sync source with reduced timing, and a reference model
// that predicts outputs from the source position two pixel strobes earlier.
module tb_vga_sync_decoder;
  localparam int CNT_W = 11;
  localparam int HOFS  = 8;
  localparam int HACT  = 24;
  localparam int VOFS  = 3;
  localparam int VACT  = 12;
  localparam int LOCKN = 3;

  logic clk = 1'b0;
  logic rst, pix_ce, hsync_in, vsync_in;
  logic [CNT_W-1:0] x, y, h_total, v_total, hsync_width, vsync_width;
  logic active, frame_start, locked;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .CNT_W(CNT_W), .H_ACTIVE_OFS(HOFS), .H_ACTIVE(HACT),
    .V_ACTIVE_OFS(VOFS), .V_ACTIVE(VACT), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .active(active), .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total), .hsync_width(hsync_width), .vsync_width(vsync_width)
  );

  int checks = 0;
  int errors = 0;
  // source timing and position
  int ht, hsw, vt, vsw, sv, sh, long_sv;
  bit hold;
  // reference model
  int h1_sv, h1_sh, h2_sv, h2_sh, last_esh, fs_cnt, x_exp, y_exp;
  bit valid, lock_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; on a strobe the source presents pixel (sv,sh) and the model advances.
  task automatic tick(input bit ce);
    int esv, esh, ended;
    bit boundary, lstart, win;
    pix_ce = ce;
    if (ce) begin
      hsync_in = (sh < hsw) ? 1'b0 : 1'b1;
      vsync_in = (sv < vsw) ? 1'b0 : 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ce) begin
      check("fs_idle", frame_start, 0);
      check("locked_idle", locked, lock_exp);
      if (valid) check("x_idle", x, x_exp);
      return;
    end
    esv = h2_sv; esh = h2_sh;
    h2_sv = h1_sv; h2_sh = h1_sh;
    h1_sv = sv; h1_sh = sh;
    boundary = (esv == 0 && esh == 0);
    lstart = (esh == 0);
    ended = last_esh + 1;
    last_esh = esh;
    x_exp = (esh > 2047) ? 2047 : esh;
    y_exp = esv;
    if (boundary) begin
      valid = 1'b1;
      fs_cnt++;
    end
    if (lock_exp && lstart && ended != ht) fs_cnt = 0;
    if (x_exp == 2047) fs_cnt = 0;
    lock_exp = (fs_cnt >= LOCKN + 1);
    win = lock_exp && x_exp >= HOFS && x_exp < HOFS + HACT && y_exp >= VOFS && y_exp < VOFS + VACT;
    if (valid) begin
      check("x", x, x_exp);
      check("y", y, y_exp);
    end
    check("locked", locked, lock_exp);
    check("active", active, win);
    check("frame_start", frame_start, boundary);
    sh++;
    if (!hold && sh >= ((sv == long_sv) ? ht + 1 : ht)) begin
      if (sv == long_sv) long_sv = -1;
      sh = 0;
      sv = (sv + 1) % vt;
    end
  endtask

  task automatic strobe(input bit sparse);
    if (sparse) repeat ($urandom_range(9, 0)) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic cfg_random();
    ht = $urandom_range(46, 34);
    hsw = $urandom_range(6, 2);
    vt = $urandom_range(22, 16);
    vsw = $urandom_range(3, 1);
    sv = $urandom_range(vt - 3, vsw + 2);
    sh = $urandom_range(ht - 3, hsw + 3);
    long_sv = -1;
    hold = 1'b0;
    h1_sv = sv; h1_sh = sh; h2_sv = sv; h2_sh = sh;
    last_esh = sh;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_active", active, 0);
    check("rst_fs", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_h_total", h_total, 0);
    check("rst_v_total", v_total, 0);
    check("rst_hsync_width", hsync_width, 0);
    check("rst_vsync_width", vsync_width, 0);
    rst = 1'b0;
    valid = 1'b0;
    fs_cnt = 0;
    lock_exp = 1'b0;
  endtask

  task automatic run_until_lock(input bit sparse, input string tag);
    for (int i = 0; i < 8000 && !lock_exp; i++) strobe(sparse);
    check(tag, locked, 1);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"}, h_total, ht);
    check({tag, "_v_total"}, v_total, vt);
    check({tag, "_hsync_width"}, hsync_width, hsw);
    check({tag, "_vsync_width"}, vsync_width, vsw);
  endtask

  initial begin
    int act_cnt, rises, xmin, xmax, ymin, ymax;
    bit prev_act, saw_unlock;
    rst = 1'b1; pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    valid = 1'b0; fs_cnt = 0; lock_exp = 1'b0; x_exp = 0; y_exp = 0;

    // lock on a random timing, continuous strobes
    cfg_random();
    repeat (2) @(posedge clk);
    do_reset();
    run_until_lock(1'b0, "lock_cont");
    check_meas("cont");

    // one full frame of active cycles
    act_cnt = 0; rises = 0; prev_act = 1'b0;
    xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
    for (int i = 0; i < ht * vt; i++) begin
      tick(1'b1);
      if (active) begin
        act_cnt++;
        if (int'(x) < xmin) xmin = x;
        if (int'(x) > xmax) xmax = x;
        if (int'(y) < ymin) ymin = y;
        if (int'(y) > ymax) ymax = y;
        if (!prev_act) rises++;
      end
      prev_act = active;
    end
    check("active_count", act_cnt, HACT * VACT);
    check("active_lines", rises, VACT);
    check("active_x_first", xmin, HOFS);
    check("active_x_last", xmax, HOFS + HACT - 1);
    check("active_y_first", ymin, VOFS);
    check("active_y_last", ymax, VOFS + VACT - 1);

    // one lengthened line drops lock, then relock
    long_sv = vt / 2;
    saw_unlock = 1'b0;
    for (int i = 0; i < 3000 && lock_exp; i++) begin
      tick(1'b1);
      if (!locked) saw_unlock = 1'b1;
    end
    check("long_line_unlock", saw_unlock, 1);
    run_until_lock(1'b0, "relock_long_line");
    check("relock_h_total", h_total, ht);

    // hsync held high: x saturates and lock drops
    hold = 1'b1;
    repeat (2100) tick(1'b1);
    check("timeout_x", x, 2047);
    check("timeout_locked", locked, 0);
    hold = 1'b0;
    sh = 0;
    sv = (sv + 1) % vt;

    // reset mid-frame, then relock
    for (int i = 0; i < 3000 && !(sv == vt / 2 && sh == ht / 2); i++) tick(1'b1);
    do_reset();
    run_until_lock(1'b0, "relock_after_rst");
    check_meas("after_rst");

    // new random timing with sparse random strobes
    cfg_random();
    do_reset();
    run_until_lock(1'b1, "lock_sparse");
    for (int i = 0; i < ht * vt; i++) strobe(1'b1);
    check_meas("sparse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
